// File: rtl/id_decode_branch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_decode_branch_pkg
// Purpose : Shared opcode/funct codes and control-field encodings for the
//           ID-stage decoder and branch resolver.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package id_decode_branch_pkg;

    // Primary opcodes (Instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (Instruction[5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;

    // Destination register select
    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    // Jump kind
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_IMM  = 2'b01;
    localparam logic [1:0] JUMP_REG  = 2'b10;

    // Write-back source
    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

    // ALU operation
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_MEM   = 3'b001;
    localparam logic [2:0] ALUOP_BR    = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b110;

    // HI/LO unit control
    localparam logic [1:0] HILO_NONE  = 2'b00;
    localparam logic [1:0] HILO_WRITE = 2'b01;
    localparam logic [1:0] HILO_MFHI  = 2'b10;
    localparam logic [1:0] HILO_MFLO  = 2'b11;

endpackage : id_decode_branch_pkg
`default_nettype wire

// File: rtl/id_decode_branch_add32.sv
`default_nettype none
// ============================================================================
// Module  : add32
// Purpose : 32-bit adder, result truncated to 32 bits (wraps modulo 2^32).
// Ports   : a_i, b_i - operands; sum_o - a_i + b_i
// Revision: 1.0 - initial release
// ============================================================================
module add32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule : add32
`default_nettype wire

// File: rtl/id_decode_branch.sv
`default_nettype none
// ============================================================================
// Module  : id_decode_branch
// Purpose : ID-stage control decoder with branch resolution and branch/jump
//           target generation. Control is purely combinational; a one-bit
//           reset flag forces all control outputs to zero while set.
// Ports   : CLK, RESET          - clock, synchronous active-high reset
//           Instruction, PC_4   - ID instruction and its PC+4
//           RS_Data, RT_Data    - forwarded operands for branch compare
//           RegDst, Jump, WB, MEM, EX, Branch - control outputs
//           BTB_Addr, Jump_Addr - branch and jump targets (always driven)
// Revision: 1.0 - initial release
// ============================================================================
module id_decode_branch
    import id_decode_branch_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instruction,
    input  logic [31:0] PC_4,
    input  logic [31:0] RS_Data,
    input  logic [31:0] RT_Data,
    output logic [1:0]  RegDst,
    output logic [1:0]  Jump,
    output logic [2:0]  WB,
    output logic [1:0]  MEM,
    output logic [5:0]  EX,
    output logic        Branch,
    output logic [31:0] BTB_Addr,
    output logic [31:0] Jump_Addr
);

    logic        rst_flag_q;
    logic        rst_flag_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] br_offset;
    logic        operands_equal;

    logic [1:0]  regdst_d;
    logic [1:0]  jump_d;
    logic [1:0]  memtoreg_d;
    logic        regwrite_d;
    logic        memread_d;
    logic        memwrite_d;
    logic [2:0]  aluop_d;
    logic        alusrc_d;
    logic [1:0]  hilo_d;
    logic        branch_d;

    assign opcode = Instruction[31:26];
    assign funct  = Instruction[5:0];

    // Reset flag simply tracks RESET at each rising edge.
    assign rst_flag_d = RESET;

    always_ff @(posedge CLK) begin
        rst_flag_q <= rst_flag_d;
    end

    // Targets -------------------------------------------------------------
    assign br_offset = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};

    add32 u_add_btb (
        .a_i   (PC_4),
        .b_i   (br_offset),
        .sum_o (BTB_Addr)
    );

    // The two operands occupy disjoint bit ranges, so the sum is the
    // region-preserving concatenation of PC_4[31:28] and the target field.
    add32 u_add_jmp (
        .a_i   ({PC_4[31:28], 28'd0}),
        .b_i   ({4'd0, Instruction[25:0], 2'b00}),
        .sum_o (Jump_Addr)
    );

    // Branch compare: equality as the AND-reduction of the bitwise XNOR.
    assign operands_equal = &(RS_Data ~^ RT_Data);

    // Decode --------------------------------------------------------------
    always_comb begin
        regdst_d   = REGDST_RT;
        jump_d     = JUMP_NONE;
        memtoreg_d = MEMTOREG_ALU;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        aluop_d    = ALUOP_ADD;
        alusrc_d   = 1'b0;
        hilo_d     = HILO_NONE;
        branch_d   = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                regdst_d   = REGDST_RD;
                regwrite_d = 1'b1;
                aluop_d    = ALUOP_RTYPE;
                case (funct)
                    FN_JR: begin
                        jump_d     = JUMP_REG;
                        regwrite_d = 1'b0;
                    end
                    FN_MULT, FN_DIV: begin
                        hilo_d     = HILO_WRITE;
                        regwrite_d = 1'b0;
                    end
                    FN_MFHI: hilo_d = HILO_MFHI;
                    FN_MFLO: hilo_d = HILO_MFLO;
                    default: ;
                endcase
            end
            OP_LW: begin
                memtoreg_d = MEMTOREG_MEM;
                regwrite_d = 1'b1;
                memread_d  = 1'b1;
                aluop_d    = ALUOP_MEM;
            end
            OP_SW: begin
                memwrite_d = 1'b1;
                aluop_d    = ALUOP_MEM;
            end
            OP_BEQ: begin
                aluop_d  = ALUOP_BR;
                branch_d = operands_equal;
            end
            OP_BNE: begin
                aluop_d  = ALUOP_BR;
                branch_d = ~operands_equal;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
                regwrite_d = 1'b1;
                alusrc_d   = 1'b1;
                case (opcode)
                    OP_ANDI: aluop_d = ALUOP_AND;
                    OP_ORI:  aluop_d = ALUOP_OR;
                    OP_SLTI: aluop_d = ALUOP_SLT;
                    OP_LUI:  aluop_d = ALUOP_LUI;
                    default: aluop_d = ALUOP_ADD;
                endcase
            end
            OP_J: begin
                jump_d = JUMP_IMM;
            end
            OP_JAL: begin
                jump_d     = JUMP_IMM;
                regdst_d   = REGDST_R31;
                memtoreg_d = MEMTOREG_PC4;
                regwrite_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output gating while the reset flag is set.
    always_comb begin
        if (rst_flag_q) begin
            RegDst = 2'b00;
            Jump   = 2'b00;
            WB     = 3'b000;
            MEM    = 2'b00;
            EX     = 6'b000000;
            Branch = 1'b0;
        end else begin
            RegDst = regdst_d;
            Jump   = jump_d;
            WB     = {memtoreg_d, regwrite_d};
            MEM    = {memread_d, memwrite_d};
            EX     = {aluop_d, alusrc_d, hilo_d};
            Branch = branch_d;
        end
    end

endmodule : id_decode_branch
`default_nettype wire

// File: tb/tb_id_decode_branch.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_decode_branch
// Purpose : Directed self-checking bench for id_decode_branch.
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_decode_branch;

    logic        CLK;
    logic        RESET;
    logic [31:0] Instruction;
    logic [31:0] PC_4;
    logic [31:0] RS_Data;
    logic [31:0] RT_Data;
    logic [1:0]  RegDst;
    logic [1:0]  Jump;
    logic [2:0]  WB;
    logic [1:0]  MEM;
    logic [5:0]  EX;
    logic        Branch;
    logic [31:0] BTB_Addr;
    logic [31:0] Jump_Addr;

    int checks   = 0;
    int failures = 0;

    // Packed view of all control outputs: {RegDst,Jump,WB,MEM,EX,Branch}
    logic [15:0] ctrl;
    assign ctrl = {RegDst, Jump, WB, MEM, EX, Branch};

    id_decode_branch dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Instruction (Instruction),
        .PC_4        (PC_4),
        .RS_Data     (RS_Data),
        .RT_Data     (RT_Data),
        .RegDst      (RegDst),
        .Jump        (Jump),
        .WB          (WB),
        .MEM         (MEM),
        .EX          (EX),
        .Branch      (Branch),
        .BTB_Addr    (BTB_Addr),
        .Jump_Addr   (Jump_Addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RESET = 1'b1;
        Instruction = 32'h8FA80000;
        PC_4 = 32'h0; RS_Data = 32'h0; RT_Data = 32'h0;
        @(posedge CLK); #1;
        checks++;
        if (ctrl !== 16'h0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%h exp=%h", ctrl, 16'h0000);
        end
        RESET = 1'b0;
        @(posedge CLK); #1;
        // lw: RegDst 00, Jump 00, WB 011, MEM 10, EX 001000, Branch 0
        checks++;
        if (ctrl !== {2'b00, 2'b00, 3'b011, 2'b10, 6'b001000, 1'b0}) begin
            failures++;
            $display("FAIL lw_after_reset got=%h exp=%h", ctrl,
                     {2'b00, 2'b00, 3'b011, 2'b10, 6'b001000, 1'b0});
        end
    endtask

    task automatic test_rtype();
        Instruction = 32'h00A63820; RS_Data = 32'h7; RT_Data = 32'h7; #1;
        checks++;
        if (ctrl !== {2'b01, 2'b00, 3'b001, 2'b00, 6'b010000, 1'b0}) begin
            failures++;
            $display("FAIL add got=%h exp=%h", ctrl, {2'b01, 2'b00, 3'b001, 2'b00, 6'b010000, 1'b0});
        end
        Instruction = 32'h00850018; #1; // mult
        checks++;
        if (ctrl !== {2'b01, 2'b00, 3'b000, 2'b00, 6'b010001, 1'b0}) begin
            failures++;
            $display("FAIL mult got=%h exp=%h", ctrl, {2'b01, 2'b00, 3'b000, 2'b00, 6'b010001, 1'b0});
        end
        Instruction = 32'h0085001A; #1; // div
        checks++;
        if (ctrl !== {2'b01, 2'b00, 3'b000, 2'b00, 6'b010001, 1'b0}) begin
            failures++;
            $display("FAIL div got=%h exp=%h", ctrl, {2'b01, 2'b00, 3'b000, 2'b00, 6'b010001, 1'b0});
        end
        Instruction = 32'h00001010; #1; // mfhi
        checks++;
        if (ctrl !== {2'b01, 2'b00, 3'b001, 2'b00, 6'b010010, 1'b0}) begin
            failures++;
            $display("FAIL mfhi got=%h exp=%h", ctrl, {2'b01, 2'b00, 3'b001, 2'b00, 6'b010010, 1'b0});
        end
        Instruction = 32'h00001012; #1; // mflo
        checks++;
        if (ctrl !== {2'b01, 2'b00, 3'b001, 2'b00, 6'b010011, 1'b0}) begin
            failures++;
            $display("FAIL mflo got=%h exp=%h", ctrl, {2'b01, 2'b00, 3'b001, 2'b00, 6'b010011, 1'b0});
        end
        Instruction = 32'h03E00008; #1; // jr $31
        checks++;
        if (ctrl !== {2'b01, 2'b10, 3'b000, 2'b00, 6'b010000, 1'b0}) begin
            failures++;
            $display("FAIL jr got=%h exp=%h", ctrl, {2'b01, 2'b10, 3'b000, 2'b00, 6'b010000, 1'b0});
        end
        Instruction = 32'h00000000; #1; // all-zero NOP writes $0
        checks++;
        if (ctrl !== {2'b01, 2'b00, 3'b001, 2'b00, 6'b010000, 1'b0}) begin
            failures++;
            $display("FAIL nop_zero got=%h exp=%h", ctrl, {2'b01, 2'b00, 3'b001, 2'b00, 6'b010000, 1'b0});
        end
    endtask

    task automatic test_itype();
        Instruction = 32'h20080005; #1; // addi
        checks++;
        if (ctrl !== {2'b00, 2'b00, 3'b001, 2'b00, 6'b000100, 1'b0}) begin
            failures++;
            $display("FAIL addi got=%h exp=%h", ctrl, {2'b00, 2'b00, 3'b001, 2'b00, 6'b000100, 1'b0});
        end
        Instruction = 32'h3108000F; #1; // andi
        checks++;
        if (EX !== 6'b011100) begin
            failures++;
            $display("FAIL andi_ex got=%b exp=%b", EX, 6'b011100);
        end
        Instruction = 32'h3508000F; #1; // ori
        checks++;
        if (EX !== 6'b100100) begin
            failures++;
            $display("FAIL ori_ex got=%b exp=%b", EX, 6'b100100);
        end
        Instruction = 32'h2908000F; #1; // slti
        checks++;
        if (EX !== 6'b101100) begin
            failures++;
            $display("FAIL slti_ex got=%b exp=%b", EX, 6'b101100);
        end
        Instruction = 32'h3C081234; #1; // lui
        checks++;
        if (ctrl !== {2'b00, 2'b00, 3'b001, 2'b00, 6'b110100, 1'b0}) begin
            failures++;
            $display("FAIL lui got=%h exp=%h", ctrl, {2'b00, 2'b00, 3'b001, 2'b00, 6'b110100, 1'b0});
        end
        Instruction = 32'hAFA80000; #1; // sw
        checks++;
        if (ctrl !== {2'b00, 2'b00, 3'b000, 2'b01, 6'b001000, 1'b0}) begin
            failures++;
            $display("FAIL sw got=%h exp=%h", ctrl, {2'b00, 2'b00, 3'b000, 2'b01, 6'b001000, 1'b0});
        end
        Instruction = 32'hFC000000; #1; // unlisted opcode
        checks++;
        if (ctrl !== 16'h0000) begin
            failures++;
            $display("FAIL unlisted got=%h exp=%h", ctrl, 16'h0000);
        end
    endtask

    task automatic test_branch();
        Instruction = 32'h110A0000; PC_4 = 32'h4; RS_Data = 32'h8; RT_Data = 32'h8; #1;
        checks++;
        if (ctrl !== {2'b00, 2'b00, 3'b000, 2'b00, 6'b001000, 1'b1}) begin
            failures++;
            $display("FAIL beq_taken got=%h exp=%h", ctrl, {2'b00, 2'b00, 3'b000, 2'b00, 6'b001000, 1'b1});
        end
        checks++;
        if (BTB_Addr !== 32'h00000004) begin
            failures++;
            $display("FAIL beq_btb got=%h exp=%h", BTB_Addr, 32'h00000004);
        end
        RT_Data = 32'h2; #1;
        checks++;
        if (Branch !== 1'b0) begin
            failures++;
            $display("FAIL beq_not_taken got=%b exp=0", Branch);
        end
        RS_Data = 32'h80000000; RT_Data = 32'h00000000; #1; // differ only in MSB
        checks++;
        if (Branch !== 1'b0) begin
            failures++;
            $display("FAIL beq_msb got=%b exp=0", Branch);
        end
        Instruction = 32'h15090000; RS_Data = 32'h0; RT_Data = 32'h0; #1;
        checks++;
        if (Branch !== 1'b0) begin
            failures++;
            $display("FAIL bne_equal got=%b exp=0", Branch);
        end
        RT_Data = 32'h5; #1;
        checks++;
        if (Branch !== 1'b1) begin
            failures++;
            $display("FAIL bne_diff got=%b exp=1", Branch);
        end
        // positive offset: 0x100 + (0x10 << 2) = 0x140
        Instruction = 32'h10000010; PC_4 = 32'h00000100; #1;
        checks++;
        if (BTB_Addr !== 32'h00000140) begin
            failures++;
            $display("FAIL btb_pos got=%h exp=%h", BTB_Addr, 32'h00000140);
        end
        // negative offset with wrap: 0 + (-1 << 2) = 0xFFFFFFFC
        Instruction = 32'h1000FFFF; PC_4 = 32'h0; #1;
        checks++;
        if (BTB_Addr !== 32'hFFFFFFFC) begin
            failures++;
            $display("FAIL btb_wrap got=%h exp=%h", BTB_Addr, 32'hFFFFFFFC);
        end
    endtask

    task automatic test_jump();
        Instruction = 32'h08000001; PC_4 = 32'h40000004; #1;
        checks++;
        if (ctrl !== {2'b00, 2'b01, 3'b000, 2'b00, 6'b000000, 1'b0}) begin
            failures++;
            $display("FAIL j_ctrl got=%h exp=%h", ctrl, {2'b00, 2'b01, 3'b000, 2'b00, 6'b000000, 1'b0});
        end
        checks++;
        if (Jump_Addr !== 32'h40000004) begin
            failures++;
            $display("FAIL j_addr got=%h exp=%h", Jump_Addr, 32'h40000004);
        end
        Instruction = 32'h0C000010; PC_4 = 32'hF0001000; #1;
        checks++;
        if (ctrl !== {2'b10, 2'b01, 3'b101, 2'b00, 6'b000000, 1'b0}) begin
            failures++;
            $display("FAIL jal_ctrl got=%h exp=%h", ctrl, {2'b10, 2'b01, 3'b101, 2'b00, 6'b000000, 1'b0});
        end
        checks++;
        if (Jump_Addr !== 32'hF0000040) begin
            failures++;
            $display("FAIL jal_addr got=%h exp=%h", Jump_Addr, 32'hF0000040);
        end
        // jump target is driven for a non-jump opcode too
        Instruction = 32'h23FFFFFF; PC_4 = 32'h00000000; #1;
        checks++;
        if (Jump_Addr !== 32'h0FFFFFFC) begin
            failures++;
            $display("FAIL jaddr_any got=%h exp=%h", Jump_Addr, 32'h0FFFFFFC);
        end
    endtask

    task automatic test_back_to_back();
        Instruction = 32'h110A0000; PC_4 = 32'h8; RS_Data = 32'h3; RT_Data = 32'h3;
        @(negedge CLK);
        RESET = 1'b1; #1;
        checks++; // reset takes effect only at the next edge
        if (Branch !== 1'b1) begin
            failures++;
            $display("FAIL pre_edge_branch got=%b exp=1", Branch);
        end
        @(posedge CLK); #1;
        checks++;
        if (ctrl !== 16'h0000) begin
            failures++;
            $display("FAIL midreset_ctrl got=%h exp=%h", ctrl, 16'h0000);
        end
        checks++; // targets stay live under reset
        if (BTB_Addr !== 32'h00000008) begin
            failures++;
            $display("FAIL midreset_btb got=%h exp=%h", BTB_Addr, 32'h00000008);
        end
        RESET = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (Branch !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_branch got=%b exp=1", Branch);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_branch();
        test_jump();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_decode_branch
`default_nettype wire
